atmega_pcint: RTL and testbench

- Pin-input front end and pin-change interrupt controller for one GPIO port.
- Synchronises and optionally debounces raw pad inputs.
- Its synchronised vector drives the PIO's io_in, so PIN reads never see metastable data.
- Flags masked pin transitions and raises an interrupt request to the core's vector unit, with AVR-style PCICR/PCIFR/PCMSK registers on the same 8-bit IO data bus.

---
 rtl/atmega_pcint.sv | 240 ++++++++++++++++++++++++
 tb/tb_atmega_pcint.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atmega_pcint.sv
// -----------------------------------------------------------------------------
// atmega_pcint
//
// Pin-input front end and pin-change interrupt controller for one GPIO port.
//
// Raw pad inputs pass through a per-pin synchroniser chain and an optional
// debounce filter. The cleaned vector (pin_sync) feeds the PIO's io_in, so PIN
// reads never see metastable data. Masked transitions on pin_sync (rising or
// falling) set the PCIF flag, and PCIF & PCIE drives a level interrupt request
// to the core's vector unit. AVR-style PCICR / PCIFR / PCMSK registers sit on
// the 8-bit IO data bus.
//
// Ports
//   rst          in   asynchronous, active-high reset
//   clk          in   core clock
//   addr_dat     in   IO register address
//   wr_dat       in   write strobe, one cycle
//   rd_dat       in   read strobe
//   bus_dat_in   in   write data
//   bus_dat_out  out  read data, combinational
//   pin_in       in   raw asynchronous pad inputs
//   pin_sync     out  synchronised / filtered pins, to the PIO io_in
//   int_req      out  interrupt request, level
//   int_ack      in   one-cycle acknowledge from the vector unit
//
// Register map
//   PCICR_ADDR  bit0 = PCIE (interrupt enable)
//   PCIFR_ADDR  bit0 = PCIF (flag, write 1 to clear)
//   PCMSK_ADDR  per-pin change-enable mask
// -----------------------------------------------------------------------------
module atmega_pcint #(
  parameter int                             BUS_ADDR_DATA_LEN = 8,
  parameter int                             PORT_WIDTH        = 8,
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   PCICR_ADDR        = BUS_ADDR_DATA_LEN'('h68),
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   PCIFR_ADDR        = BUS_ADDR_DATA_LEN'('h3B),
  parameter logic [BUS_ADDR_DATA_LEN-1:0]   PCMSK_ADDR        = BUS_ADDR_DATA_LEN'('h6B),
  parameter int                             SYNC_STAGES       = 2,
  parameter int                             DEBOUNCE_CYCLES   = 0,
  // Physically present pins; absent bits read 0 on pin_sync and never flag.
  parameter logic [PORT_WIDTH-1:0]          PINMASK           = '1
) (
  input  logic                          rst,
  input  logic                          clk,
  input  logic [BUS_ADDR_DATA_LEN-1:0]  addr_dat,
  input  logic                          wr_dat,
  input  logic                          rd_dat,
  input  logic [7:0]                    bus_dat_in,
  output logic [7:0]                    bus_dat_out,
  input  logic [PORT_WIDTH-1:0]         pin_in,
  output logic [PORT_WIDTH-1:0]         pin_sync,
  output logic                          int_req,
  input  logic                          int_ack
);

  // ---------------------------------------------------------------------------
  // Local parameters
  // ---------------------------------------------------------------------------
  // The init phase covers the synchroniser fill plus one cycle for the
  // previous-value register to catch up with the settled pins.
  localparam int INIT_CYCLES = SYNC_STAGES + 1;
  localparam int INIT_W      = $clog2(INIT_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // Synchroniser chain: stage 0 samples the pad, last stage is sync_out.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][PORT_WIDTH-1:0] sync_q;
  logic [PORT_WIDTH-1:0]                  sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
    end
  end

  // ---------------------------------------------------------------------------
  // Init phase counter. While active, the filter follows sync_out directly
  // and change detection is suppressed, so pins already high at reset release
  // never raise a flag.
  // ---------------------------------------------------------------------------
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_active;

  assign init_active = (init_cnt_q < INIT_W'(INIT_CYCLES));
  assign init_cnt_d  = init_active ? (init_cnt_q + INIT_W'(1)) : init_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt_q <= '0;
    end else begin
      init_cnt_q <= init_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce filter.
  //   filtered     : current filtered vector
  //   filtered_nxt : value filtered takes after the next edge; used to preload
  //                  the previous-value register during init so that the
  //                  first post-init cycle sees no artificial transition.
  // ---------------------------------------------------------------------------
  logic [PORT_WIDTH-1:0] filtered;
  logic [PORT_WIDTH-1:0] filtered_nxt;

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign filtered     = sync_out;
    assign filtered_nxt = sync_q[SYNC_STAGES-2];
  end else begin : g_filter
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // The update happens on the edge at which the count would reach
    // DEBOUNCE_CYCLES, so a level must disagree with filtered for exactly
    // DEBOUNCE_CYCLES consecutive cycles before it is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [PORT_WIDTH-1:0]            filt_q, filt_d;
    logic [PORT_WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets its default before the per-bit decisions, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
      filt_d = filt_q;
      cnt_d  = cnt_q;
      for (int i = 0; i < PORT_WIDTH; i++) begin
        if (init_active) begin
          filt_d[i] = sync_out[i];
          cnt_d[i]  = '0;
        end else if (sync_out[i] == filt_q[i]) begin
          cnt_d[i]  = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync_out[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i]  = cnt_q[i] + CNT_W'(1);
        end
      end
    end

    // NOTE: the per-pin counter array is reset along with everything else; a
    // reset mid-debounce must not leave a partial count behind.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        filt_q <= '0;
        cnt_q  <= '0;
      end else begin
        filt_q <= filt_d;
        cnt_q  <= cnt_d;
      end
    end

    assign filtered     = filt_q;
    assign filtered_nxt = filt_d;
  end

  assign pin_sync = filtered & PINMASK;

  // ---------------------------------------------------------------------------
  // Register write decode
  // ---------------------------------------------------------------------------
  logic wr_pcicr, wr_pcifr, wr_pcmsk;

  assign wr_pcicr = wr_dat && (addr_dat == PCICR_ADDR);
  assign wr_pcifr = wr_dat && (addr_dat == PCIFR_ADDR);
  assign wr_pcmsk = wr_dat && (addr_dat == PCMSK_ADDR);

  // ---------------------------------------------------------------------------
  // Edge detect and flag
  // ---------------------------------------------------------------------------
  logic [PORT_WIDTH-1:0] prev_q, prev_d;
  logic [PORT_WIDTH-1:0] pcmsk_q, pcmsk_d;
  logic                  pcie_q, pcie_d;
  logic                  pcif_q, pcif_d;
  logic [PORT_WIDTH-1:0] change;
  logic                  pcif_set, pcif_clr;

  // Uses the registered mask, so a PCMSK write lands one cycle later and a
  // change in the write cycle is judged against the old mask.
  assign change   = (pin_sync ^ prev_q) & pcmsk_q & PINMASK;
  assign pcif_set = !init_active && (|change);
  assign pcif_clr = (wr_pcifr && bus_dat_in[0]) || int_ack;

  always_comb begin
    prev_d  = init_active ? (filtered_nxt & PINMASK) : pin_sync;
    pcmsk_d = wr_pcmsk ? bus_dat_in[PORT_WIDTH-1:0] : pcmsk_q;
    pcie_d  = wr_pcicr ? bus_dat_in[0] : pcie_q;
    // Set has priority: a transition arriving with a clear keeps the flag.
    pcif_d  = pcif_q;
    if (pcif_set) begin
      pcif_d = 1'b1;
    end else if (pcif_clr) begin
      pcif_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= '0;
      pcmsk_q <= '0;
      pcie_q  <= 1'b0;
      pcif_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pcmsk_q <= pcmsk_d;
      pcie_q  <= pcie_d;
      pcif_q  <= pcif_d;
    end
  end

  // Level request straight from the registers; clearing PCIE masks it while
  // PCIF stays pending.
  assign int_req = pcif_q && pcie_q;

  // ---------------------------------------------------------------------------
  // Read mux (no side effects)
  // ---------------------------------------------------------------------------
  logic [7:0] pcmsk_ext;

  always_comb begin
    pcmsk_ext                 = '0;
    pcmsk_ext[PORT_WIDTH-1:0] = pcmsk_q;
  end

  always_comb begin
    bus_dat_out = '0;
    if (rd_dat && !rst) begin
      if (addr_dat == PCICR_ADDR) begin
        bus_dat_out = {7'b0, pcie_q};
      end else if (addr_dat == PCIFR_ADDR) begin
        bus_dat_out = {7'b0, pcif_q};
      end else if (addr_dat == PCMSK_ADDR) begin
        bus_dat_out = pcmsk_ext;
      end
    end
  end

endmodule

// File: tb/tb_atmega_pcint.sv
// -----------------------------------------------------------------------------
// tb_atmega_pcint
//
// Two instances share one set of stimulus: u_a with the filter bypassed and
// all pins present, u_b with a 4-cycle debounce and pin 7 absent. A reference
// model describes the expected behaviour in terms of input history: pin_sync
// is a delayed copy of pin_in, the filter accepts a level once it has
// disagreed with the filtered value for a full window, and PCIF rises on any
// masked difference between consecutive pin_sync values after init.
// -----------------------------------------------------------------------------
module tb_atmega_pcint;

  localparam int         S      = 2;
  localparam int         D_B    = 4;
  localparam logic [7:0] PM_A   = 8'hFF;
  localparam logic [7:0] PM_B   = 8'h7F;
  localparam logic [7:0] A_CR   = 8'h68;
  localparam logic [7:0] A_FR   = 8'h3B;
  localparam logic [7:0] A_MSK  = 8'h6B;

  logic       clk;
  logic       rst;
  logic [7:0] addr_dat;
  logic       wr_dat;
  logic       rd_dat;
  logic [7:0] bus_dat_in;
  logic [7:0] pin_in;
  logic       int_ack;

  logic [7:0] bus_a, bus_b;
  logic [7:0] ps_a, ps_b;
  logic       irq_a, irq_b;

  atmega_pcint u_a (
    .rst         (rst),
    .clk         (clk),
    .addr_dat    (addr_dat),
    .wr_dat      (wr_dat),
    .rd_dat      (rd_dat),
    .bus_dat_in  (bus_dat_in),
    .bus_dat_out (bus_a),
    .pin_in      (pin_in),
    .pin_sync    (ps_a),
    .int_req     (irq_a),
    .int_ack     (int_ack)
  );

  atmega_pcint #(
    .DEBOUNCE_CYCLES (D_B),
    .PINMASK         (PM_B)
  ) u_b (
    .rst         (rst),
    .clk         (clk),
    .addr_dat    (addr_dat),
    .wr_dat      (wr_dat),
    .rd_dat      (rd_dat),
    .bus_dat_in  (bus_dat_in),
    .bus_dat_out (bus_b),
    .pin_in      (pin_in),
    .pin_sync    (ps_b),
    .int_req     (irq_b),
    .int_ack     (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [7:0] pq[$];            // pin_in samples since release, [0] = newest
  int         k_m      = 0;     // edges since reset release
  logic       pcie_m   = 1'b0;
  logic [7:0] msk_m    = 8'h00;
  logic       pcif_m[2];
  logic [7:0] filt_m[2];
  logic [7:0] ps1_m[2];         // pin_sync after the latest edge
  logic [7:0] ps2_m[2];         // pin_sync after the edge before

  initial begin
    for (int i = 0; i < 2; i++) begin
      pcif_m[i] = 1'b0;
      filt_m[i] = 8'h00;
      ps1_m[i]  = 8'h00;
      ps2_m[i]  = 8'h00;
    end
  end

  function automatic logic [7:0] samp(input int i);
    return (i < pq.size()) ? pq[i] : 8'h00;
  endfunction

  always @(posedge clk) begin : model_upd
    int         kn;
    int         d;
    logic       clr;
    logic       set;
    logic       all_diff;
    logic [7:0] pm;
    logic [7:0] sv;
    if (rst) begin
      pq.delete();
      k_m    = 0;
      pcie_m = 1'b0;
      msk_m  = 8'h00;
      for (int i = 0; i < 2; i++) begin
        pcif_m[i] = 1'b0;
        filt_m[i] = 8'h00;
        ps1_m[i]  = 8'h00;
        ps2_m[i]  = 8'h00;
      end
    end else begin
      kn  = (k_m < 1000) ? k_m + 1 : k_m;
      clr = (wr_dat && addr_dat == A_FR && bus_dat_in[0]) || int_ack;
      for (int i = 0; i < 2; i++) begin
        pm  = (i == 0) ? PM_A : PM_B;
        d   = (i == 0) ? 0 : D_B;
        set = (kn >= S + 3) && (((ps1_m[i] ^ ps2_m[i]) & msk_m & pm) != 8'h00);
        if (set) pcif_m[i] = 1'b1;
        else if (clr) pcif_m[i] = 1'b0;
        if (d > 0) begin
          if (kn <= S + 1) begin
            filt_m[i] = samp(S - 1);
          end else if (kn - d + 1 >= S + 2) begin
            for (int b = 0; b < 8; b++) begin
              all_diff = 1'b1;
              for (int j = 0; j < d; j++) begin
                sv = samp(S - 1 + j);
                if (sv[b] == filt_m[i][b]) all_diff = 1'b0;
              end
              if (all_diff) filt_m[i][b] = ~filt_m[i][b];
            end
          end
        end
      end
      if (wr_dat && addr_dat == A_CR)  pcie_m = bus_dat_in[0];
      if (wr_dat && addr_dat == A_MSK) msk_m  = bus_dat_in;
      pq.push_front(pin_in);
      if (pq.size() > 16) void'(pq.pop_back());
      for (int i = 0; i < 2; i++) begin
        pm = (i == 0) ? PM_A : PM_B;
        ps2_m[i] = ps1_m[i];
        ps1_m[i] = (i == 0) ? (samp(S - 1) & pm) : (filt_m[i] & pm);
      end
      k_m = kn;
    end
  end

  function automatic logic [7:0] exp_rd(input int i);
    if (!rd_dat || rst)       return 8'h00;
    if (addr_dat == A_CR)     return {7'b0, pcie_m};
    if (addr_dat == A_FR)     return {7'b0, pcif_m[i]};
    if (addr_dat == A_MSK)    return msk_m;
    return 8'h00;
  endfunction

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    check("pin_sync_a", ps_a, rst ? 8'h00 : ps1_m[0]);
    check("pin_sync_b", ps_b, rst ? 8'h00 : ps1_m[1]);
    check("int_req_a", {7'b0, irq_a}, rst ? 8'h00 : {7'b0, pcif_m[0] & pcie_m});
    check("int_req_b", {7'b0, irq_b}, rst ? 8'h00 : {7'b0, pcif_m[1] & pcie_m});
    check("bus_out_a", bus_a, exp_rd(0));
    check("bus_out_b", bus_b, exp_rd(1));
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 ns after the rising edge.
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] dat);
    addr_dat   = a;
    bus_dat_in = dat;
    wr_dat     = 1'b1;
    step();
    wr_dat     = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a,
                        input logic [7:0] exp_a, input logic [7:0] exp_b);
    addr_dat = a;
    rd_dat   = 1'b1;
    #1;
    check({name, "_a"}, bus_a, exp_a);
    check({name, "_b"}, bus_b, exp_b);
    rd_dat   = 1'b0;
  endtask

  int rst_hold;
  int r;

  initial begin
    rst        = 1'b1;
    pin_in     = 8'hFF;
    wr_dat     = 1'b0;
    rd_dat     = 1'b0;
    int_ack    = 1'b0;
    addr_dat   = 8'h00;
    bus_dat_in = 8'h00;
    idle(3);

    // Pins high through reset: they appear but never flag.
    rst = 1'b0;
    step();
    step(); #1 check("rst_pins_a", ps_a, 8'hFF);
    step(); #1 check("rst_pins_b", ps_b, 8'h7F);
    bus_wr(A_MSK, 8'hFF);
    bus_wr(A_CR, 8'h01);
    idle(6);
    #1 check("init_noflag_a", {7'b0, irq_a}, 8'h00);
    check("init_noflag_b", {7'b0, irq_b}, 8'h00);
    rd_chk("init_pcifr", A_FR, 8'h00, 8'h00);

    // All pins fall: A flags 2 edges later, B 2+4 edges later.
    pin_in = 8'h00;
    step();
    step(); #1 check("fall_ps_a", ps_a, 8'h00);
    check("fall_irq_a_early", {7'b0, irq_a}, 8'h00);
    step(); #1 check("fall_irq_a", {7'b0, irq_a}, 8'h01);
    step();
    step(); #1 check("fall_ps_b_hold", ps_b, 8'h7F);
    step(); #1 check("fall_ps_b", ps_b, 8'h00);
    check("fall_irq_b_early", {7'b0, irq_b}, 8'h00);
    step(); #1 check("fall_irq_b", {7'b0, irq_b}, 8'h01);

    // Writing 0 to PCIFR leaves the flag; writing 1 clears it.
    bus_wr(A_FR, 8'h00); #1 check("pcifr_w0", {7'b0, irq_a}, 8'h01);
    bus_wr(A_FR, 8'h01); #1 check("pcifr_w1_a", {7'b0, irq_a}, 8'h00);
    check("pcifr_w1_b", {7'b0, irq_b}, 8'h00);

    // Mask = pin 2 only: pin 3 rising is ignored, pin 2 rising flags.
    bus_wr(A_MSK, 8'h04);
    pin_in = 8'h08;
    idle(8);
    #1 check("unmasked_a", {7'b0, irq_a}, 8'h00);
    check("unmasked_b", {7'b0, irq_b}, 8'h00);
    pin_in = 8'h0C;
    step();
    step(); #1 check("pin2_early", {7'b0, irq_a}, 8'h00);
    step(); #1 check("pin2_irq_a", {7'b0, irq_a}, 8'h01);
    idle(4);
    #1 check("pin2_irq_b", {7'b0, irq_b}, 8'h01);

    // int_ack clears.
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    #1 check("ack_a", {7'b0, irq_a}, 8'h00);
    check("ack_b", {7'b0, irq_b}, 8'h00);

    // Clear in the same cycle as a new masked change: set wins.
    pin_in = 8'h08;
    step();
    step();
    bus_wr(A_FR, 8'h01);
    #1 check("set_wins", {7'b0, irq_a}, 8'h01);
    idle(5);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    #1 check("ack2_b", {7'b0, irq_b}, 8'h00);

    // PCIE masks the request but keeps PCIF; re-enabling raises it next cycle.
    bus_wr(A_CR, 8'h00);
    pin_in = 8'h0C;
    idle(8);
    #1 check("pcie_off", {7'b0, irq_a}, 8'h00);
    bus_wr(A_CR, 8'h01);
    #1 check("pcie_on", {7'b0, irq_a}, 8'h01);
    rd_chk("rd_pcicr", A_CR, 8'h01, 8'h01);
    rd_chk("rd_pcifr", A_FR, 8'h01, 8'h01);
    rd_chk("rd_pcmsk", A_MSK, 8'h04, 8'h04);
    rd_chk("rd_unmapped", 8'h00, 8'h00, 8'h00);
    bus_wr(A_FR, 8'h01);

    // Debounce: a 3-cycle glitch is swallowed by B.
    bus_wr(A_MSK, 8'h01);
    pin_in = 8'h0D;
    idle(3);
    pin_in = 8'h0C;
    idle(10);
    #1 check("glitch_ps_b", ps_b, 8'h0C);
    check("glitch_irq_b", {7'b0, irq_b}, 8'h00);
    bus_wr(A_FR, 8'h01);

    // A long high level passes after the full window.
    pin_in = 8'h0D;
    idle(5);
    #1 check("deb_ps_b_hold", ps_b, 8'h0C);
    step(); #1 check("deb_ps_b", ps_b, 8'h0D);
    check("deb_irq_b_early", {7'b0, irq_b}, 8'h00);
    step(); #1 check("deb_irq_b", {7'b0, irq_b}, 8'h01);
    idle(4);

    // Reset mid-debounce with flags pending: everything clears immediately.
    pin_in = 8'h0C;
    idle(3);
    addr_dat = A_CR;
    rd_dat   = 1'b1;
    rst      = 1'b1;
    #1 check("rst_ps_a", ps_a, 8'h00);
    check("rst_ps_b", ps_b, 8'h00);
    check("rst_irq_a", {7'b0, irq_a}, 8'h00);
    check("rst_irq_b", {7'b0, irq_b}, 8'h00);
    check("rst_bus_a", bus_a, 8'h00);
    rd_dat = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(12);
    rd_chk("post_rst_pcifr", A_FR, 8'h00, 8'h00);
    #1 check("post_rst_ps_a", ps_a, 8'h0C);
    check("post_rst_ps_b", ps_b, 8'h0C);

    // Randomised traffic, checked every cycle against the model.
    rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      wr_dat  = 1'b0;
      rd_dat  = 1'b0;
      int_ack = 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 3) == 0) pin_in = 8'($urandom);
        else pin_in = pin_in ^ (8'h01 << $urandom_range(0, 7));
      end
      r = int'($urandom_range(0, 15));
      case (r)
        0: begin addr_dat = A_MSK; bus_dat_in = 8'($urandom); wr_dat = 1'b1; end
        1: begin addr_dat = A_CR;  bus_dat_in = 8'($urandom); wr_dat = 1'b1; end
        2: begin addr_dat = A_FR;  bus_dat_in = 8'($urandom); wr_dat = 1'b1; end
        3: begin addr_dat = 8'($urandom); bus_dat_in = 8'($urandom); wr_dat = 1'b1; end
        4: begin addr_dat = A_FR;  rd_dat = 1'b1; end
        5: begin addr_dat = A_CR;  rd_dat = 1'b1; end
        6: begin addr_dat = A_MSK; rd_dat = 1'b1; end
        7: begin addr_dat = 8'($urandom); rd_dat = 1'b1; end
        8: int_ack = 1'b1;
        default: ;
      endcase
      if (rst_hold > 0) begin
        rst_hold--;
      end else if ($urandom_range(0, 399) == 0) begin
        rst_hold = int'($urandom_range(1, 3));
      end
      rst = (rst_hold > 0);
      step();
    end

    rst     = 1'b0;
    wr_dat  = 1'b0;
    rd_dat  = 1'b0;
    int_ack = 1'b0;
    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
